// File: rtl/fpu_sb_pkg.sv
// Shared types, defaults and width helper for the FP register scoreboard.
package fpu_sb_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_DONE  = 2'd2
  } sb_state_e;

  localparam int unsigned DEF_NUM_REGS     = 32;
  localparam int unsigned DEF_MAX_INFLIGHT = 4;
  localparam bit          DEF_WAW_STALL    = 1'b1;
  localparam bit          DEF_WB_BYPASS    = 1'b1;

  // Bits needed to hold values 0..max_val inclusive.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/fpu_sb_regcnt.sv
// One per-register pending-write counter: saturating up/down with a registered busy flag.
module fpu_sb_regcnt
  import fpu_sb_pkg::*;
#(
  parameter  int unsigned MAX_CNT = DEF_MAX_INFLIGHT,
  localparam int unsigned CW      = cnt_width(MAX_CNT)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          inc_i,
  input  logic          dec_i,
  output logic [CW-1:0] cnt_o,
  output logic          busy_o,
  output logic          underflow_o
);

  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_CNT);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          busy_q;

  always_comb begin
    cnt_d       = cnt_q;
    underflow_o = 1'b0;
    unique case ({inc_i, dec_i})
      2'b10: if (cnt_q != CNT_MAX) cnt_d = cnt_q + CW'(1);
      2'b01: begin
        if (cnt_q != '0) cnt_d = cnt_q - CW'(1);
        else             underflow_o = 1'b1;
      end
      // A writeback against an empty counter is spurious; the new issue still counts.
      2'b11: begin
        if (cnt_q == '0) begin
          cnt_d       = CW'(1);
          underflow_o = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      busy_q <= (cnt_d != '0);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) assert (!(inc_i && !dec_i && (cnt_q == CNT_MAX)));
  end

  assign cnt_o  = cnt_q;
  assign busy_o = busy_q;

endmodule

// File: rtl/fpu_scoreboard.sv
// FP register scoreboard: RAW/WAW/in-flight issue gating with a drain handshake.
module fpu_scoreboard
  import fpu_sb_pkg::*;
#(
  parameter  int unsigned NUM_REGS     = DEF_NUM_REGS,
  parameter  int unsigned MAX_INFLIGHT = DEF_MAX_INFLIGHT,
  parameter  bit          WAW_STALL    = DEF_WAW_STALL,
  parameter  bit          WB_BYPASS    = DEF_WB_BYPASS,
  localparam int unsigned RW           = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1,
  localparam int unsigned IW           = cnt_width(MAX_INFLIGHT)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                issue_valid,
  input  logic [RW-1:0]       issue_rs1,
  input  logic [RW-1:0]       issue_rs2,
  input  logic                issue_rs1_en,
  input  logic                issue_rs2_en,
  input  logic [RW-1:0]       issue_rd,
  input  logic                issue_wb_en,
  input  logic                flush_in,
  input  logic                complete_valid,
  input  logic [RW-1:0]       complete_rd,
  input  logic                drain_req,
  output logic                issue_ready,
  output logic                stall_out,
  output logic [NUM_REGS-1:0] busy_vec,
  output logic [IW-1:0]       inflight_cnt,
  output logic                drained,
  output logic                err_underflow
);

  sb_state_e         state_q;
  logic [IW-1:0]     inflight_q, inflight_d;
  logic              drained_q, err_q;
  logic [IW-1:0]     reg_cnt [NUM_REGS];
  logic [NUM_REGS-1:0] reg_uflow;
  logic              raw_haz, waw_haz, full, issue_fire, comp_ok, uflow_evt;

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
    fpu_sb_regcnt #(.MAX_CNT(MAX_INFLIGHT)) u_cnt (
      .clk         (clk),
      .rst         (rst),
      .inc_i       (issue_fire && issue_wb_en && (issue_rd == RW'(i))),
      .dec_i       (complete_valid && (complete_rd == RW'(i))),
      .cnt_o       (reg_cnt[i]),
      .busy_o      (busy_vec[i]),
      .underflow_o (reg_uflow[i])
    );
  end

  // A hazard on a register is lifted early when its last pending write lands this cycle.
  always_comb begin
    raw_haz = 1'b0;
    waw_haz = 1'b0;
    if (issue_rs1_en && busy_vec[issue_rs1] &&
        !(WB_BYPASS && complete_valid && (complete_rd == issue_rs1) &&
          (reg_cnt[issue_rs1] == IW'(1))))
      raw_haz = 1'b1;
    if (issue_rs2_en && busy_vec[issue_rs2] &&
        !(WB_BYPASS && complete_valid && (complete_rd == issue_rs2) &&
          (reg_cnt[issue_rs2] == IW'(1))))
      raw_haz = 1'b1;
    if (WAW_STALL && issue_wb_en && busy_vec[issue_rd] &&
        !(WB_BYPASS && complete_valid && (complete_rd == issue_rd) &&
          (reg_cnt[issue_rd] == IW'(1))))
      waw_haz = 1'b1;
  end

  assign full        = (inflight_q == IW'(MAX_INFLIGHT)) && !complete_valid;
  assign issue_ready = !raw_haz && !waw_haz && !full && (state_q == ST_RUN);
  assign stall_out   = issue_valid && !issue_ready;
  assign issue_fire  = issue_valid && issue_ready && !flush_in;
  assign comp_ok     = complete_valid && (inflight_q != '0);
  assign uflow_evt   = complete_valid && ((inflight_q == '0) || (|reg_uflow));

  always_comb begin
    inflight_d = inflight_q;
    if (issue_fire && !comp_ok)      inflight_d = inflight_q + IW'(1);
    else if (!issue_fire && comp_ok) inflight_d = inflight_q - IW'(1);
  end

  // Drain completes on the edge where the in-flight count reaches zero with nothing issuing.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_RUN;
      drained_q  <= 1'b0;
      err_q      <= 1'b0;
      inflight_q <= '0;
    end else begin
      inflight_q <= inflight_d;
      if (uflow_evt) err_q <= 1'b1;
      unique case (state_q)
        ST_RUN: begin
          if (drain_req) begin
            if (inflight_d == '0) begin
              state_q   <= ST_DONE;
              drained_q <= 1'b1;
            end else begin
              state_q <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          if (inflight_d == '0) begin
            state_q   <= ST_DONE;
            drained_q <= 1'b1;
          end
        end
        ST_DONE: begin
          if (!drain_req) begin
            state_q   <= ST_RUN;
            drained_q <= 1'b0;
          end
        end
        default: begin
          state_q   <= ST_RUN;
          drained_q <= 1'b0;
        end
      endcase
    end
  end

  assign inflight_cnt  = inflight_q;
  assign drained       = drained_q;
  assign err_underflow = err_q;

endmodule

// File: tb/tb_fpu_scoreboard.sv
// Directed bench for fpu_scoreboard: default, no-bypass and no-WAW-stall instances on shared stimulus.
module tb_fpu_scoreboard;

  logic        clk = 1'b0;
  logic        rst;
  logic        issue_valid, rs1_en, rs2_en, wb_en, flush, cv, drain;
  logic [4:0]  rs1, rs2, rd, crd;

  logic        d_ready, d_stall, d_drained, d_err;
  logic [31:0] d_busy;
  logic [2:0]  d_cnt;
  logic        n_ready, n_stall, n_drained, n_err;
  logic [31:0] n_busy;
  logic [2:0]  n_cnt;
  logic        w_ready, w_stall, w_drained, w_err;
  logic [31:0] w_busy;
  logic [2:0]  w_cnt;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  fpu_scoreboard dut (
    .clk(clk), .rst(rst), .issue_valid(issue_valid), .issue_rs1(rs1), .issue_rs2(rs2),
    .issue_rs1_en(rs1_en), .issue_rs2_en(rs2_en), .issue_rd(rd), .issue_wb_en(wb_en),
    .flush_in(flush), .complete_valid(cv), .complete_rd(crd), .drain_req(drain),
    .issue_ready(d_ready), .stall_out(d_stall), .busy_vec(d_busy), .inflight_cnt(d_cnt),
    .drained(d_drained), .err_underflow(d_err)
  );

  fpu_scoreboard #(.WB_BYPASS(1'b0)) dut_nb (
    .clk(clk), .rst(rst), .issue_valid(issue_valid), .issue_rs1(rs1), .issue_rs2(rs2),
    .issue_rs1_en(rs1_en), .issue_rs2_en(rs2_en), .issue_rd(rd), .issue_wb_en(wb_en),
    .flush_in(flush), .complete_valid(cv), .complete_rd(crd), .drain_req(drain),
    .issue_ready(n_ready), .stall_out(n_stall), .busy_vec(n_busy), .inflight_cnt(n_cnt),
    .drained(n_drained), .err_underflow(n_err)
  );

  fpu_scoreboard #(.WAW_STALL(1'b0)) dut_nw (
    .clk(clk), .rst(rst), .issue_valid(issue_valid), .issue_rs1(rs1), .issue_rs2(rs2),
    .issue_rs1_en(rs1_en), .issue_rs2_en(rs2_en), .issue_rd(rd), .issue_wb_en(wb_en),
    .flush_in(flush), .complete_valid(cv), .complete_rd(crd), .drain_req(drain),
    .issue_ready(w_ready), .stall_out(w_stall), .busy_vec(w_busy), .inflight_cnt(w_cnt),
    .drained(w_drained), .err_underflow(w_err)
  );

  task automatic idle();
    issue_valid = 1'b0; rs1_en = 1'b0; rs2_en = 1'b0; wb_en = 1'b0; flush = 1'b0;
    cv = 1'b0; drain = 1'b0; rs1 = '0; rs2 = '0; rd = '0; crd = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic issue(input logic [4:0] r);
    issue_valid = 1'b1; wb_en = 1'b1; rd = r;
  endtask

  task automatic test_reset();
    rst = 1'b1; issue(5'd3); cv = 1'b1; crd = 5'd7; drain = 1'b1;
    tick();
    rst = 1'b0; idle(); #1;
    tests_run++; if (d_busy !== '0) begin tests_failed++; $display("FAIL reset_busy got %h exp 0", d_busy); end
    tests_run++; if (d_cnt !== 3'd0) begin tests_failed++; $display("FAIL reset_cnt got %0d exp 0", d_cnt); end
    tests_run++; if (d_err !== 1'b0 || d_drained !== 1'b0) begin tests_failed++; $display("FAIL reset_flags got err=%b drained=%b exp 0 0", d_err, d_drained); end
    tests_run++; if (d_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_ready got %b exp 1", d_ready); end
    tick();
    issue(5'd3);
    tick();
    idle(); #1;
    tests_run++; if (d_busy[3] !== 1'b1) begin tests_failed++; $display("FAIL midop_busy got %b exp 1", d_busy[3]); end
    rst = 1'b1; cv = 1'b1; crd = 5'd3;
    tick();
    rst = 1'b0; idle(); #1;
    tests_run++; if (d_busy !== '0 || d_cnt !== 3'd0 || d_err !== 1'b0) begin tests_failed++; $display("FAIL midop_reset got busy=%h cnt=%0d err=%b exp 0 0 0", d_busy, d_cnt, d_err); end
  endtask

  task automatic test_raw_bypass();
    do_reset();
    issue(5'd3); #1;
    tests_run++; if (d_ready !== 1'b1) begin tests_failed++; $display("FAIL raw_first_ready got %b exp 1", d_ready); end
    tick();
    rs1 = 5'd3; rs1_en = 1'b1; rd = 5'd4;
    for (int k = 0; k < 3; k++) begin
      #1;
      tests_run++; if (d_stall !== 1'b1 || n_stall !== 1'b1) begin tests_failed++; $display("FAIL raw_stall k=%0d got byp=%b nobyp=%b exp 1 1", k, d_stall, n_stall); end
      tick();
    end
    cv = 1'b1; crd = 5'd3; #1;
    tests_run++; if (d_stall !== 1'b0) begin tests_failed++; $display("FAIL raw_bypass_issue got stall=%b exp 0", d_stall); end
    tests_run++; if (n_stall !== 1'b1) begin tests_failed++; $display("FAIL raw_nobypass_wait got stall=%b exp 1", n_stall); end
    tick();
    cv = 1'b0; #1;
    tests_run++; if (n_stall !== 1'b0) begin tests_failed++; $display("FAIL raw_nobypass_issue got stall=%b exp 0", n_stall); end
    tests_run++; if (d_busy[4] !== 1'b1 || d_busy[3] !== 1'b0) begin tests_failed++; $display("FAIL raw_busy got f4=%b f3=%b exp 1 0", d_busy[4], d_busy[3]); end
    idle();
    tick();
  endtask

  task automatic test_rs2_enable();
    do_reset();
    issue(5'd8);
    tick();
    rs1 = 5'd8; rs1_en = 1'b0; rs2 = 5'd8; rs2_en = 1'b1; rd = 5'd9; #1;
    tests_run++; if (d_stall !== 1'b1) begin tests_failed++; $display("FAIL rs2_stall got %b exp 1", d_stall); end
    rs2_en = 1'b0; #1;
    tests_run++; if (d_stall !== 1'b0) begin tests_failed++; $display("FAIL rs_disabled got stall=%b exp 0", d_stall); end
    idle();
    tick();
  endtask

  task automatic test_full();
    do_reset();
    for (int r = 1; r <= 4; r++) begin
      issue(5'(r)); #1;
      tests_run++; if (d_ready !== 1'b1) begin tests_failed++; $display("FAIL full_fill r=%0d got ready=%b exp 1", r, d_ready); end
      tick();
    end
    issue(5'd5); #1;
    tests_run++; if (d_cnt !== 3'd4) begin tests_failed++; $display("FAIL full_cnt got %0d exp 4", d_cnt); end
    tests_run++; if (d_stall !== 1'b1) begin tests_failed++; $display("FAIL full_stall got %b exp 1", d_stall); end
    tick();
    cv = 1'b1; crd = 5'd1; #1;
    tests_run++; if (d_ready !== 1'b1) begin tests_failed++; $display("FAIL full_release got ready=%b exp 1", d_ready); end
    tick();
    idle(); #1;
    tests_run++; if (d_cnt !== 3'd4 || d_busy[5] !== 1'b1 || d_busy[1] !== 1'b0) begin tests_failed++; $display("FAIL full_after got cnt=%0d f5=%b f1=%b exp 4 1 0", d_cnt, d_busy[5], d_busy[1]); end
  endtask

  task automatic test_waw();
    do_reset();
    issue(5'd5); #1;
    tests_run++; if (w_ready !== 1'b1) begin tests_failed++; $display("FAIL waw_first got ready=%b exp 1", w_ready); end
    tick();
    #1;
    tests_run++; if (w_stall !== 1'b0) begin tests_failed++; $display("FAIL waw_off_issue got stall=%b exp 0", w_stall); end
    tests_run++; if (d_stall !== 1'b1) begin tests_failed++; $display("FAIL waw_on_stall got stall=%b exp 1", d_stall); end
    tick();
    idle(); #1;
    tests_run++; if (w_busy[5] !== 1'b1 || w_cnt !== 3'd2) begin tests_failed++; $display("FAIL waw_two got busy=%b cnt=%0d exp 1 2", w_busy[5], w_cnt); end
    cv = 1'b1; crd = 5'd5;
    tick();
    cv = 1'b0; #1;
    tests_run++; if (w_busy[5] !== 1'b1 || w_cnt !== 3'd1) begin tests_failed++; $display("FAIL waw_one_left got busy=%b cnt=%0d exp 1 1", w_busy[5], w_cnt); end
    cv = 1'b1;
    tick();
    cv = 1'b0; #1;
    tests_run++; if (w_busy[5] !== 1'b0 || w_cnt !== 3'd0 || w_err !== 1'b0) begin tests_failed++; $display("FAIL waw_clear got busy=%b cnt=%0d err=%b exp 0 0 0", w_busy[5], w_cnt, w_err); end
  endtask

  task automatic test_underflow();
    do_reset();
    cv = 1'b1; crd = 5'd7;
    tick();
    cv = 1'b0; #1;
    tests_run++; if (d_err !== 1'b1) begin tests_failed++; $display("FAIL uflow_set got %b exp 1", d_err); end
    tests_run++; if (d_busy !== '0 || d_cnt !== 3'd0) begin tests_failed++; $display("FAIL uflow_counters got busy=%h cnt=%0d exp 0 0", d_busy, d_cnt); end
    tick();
    tick();
    tests_run++; if (d_err !== 1'b1) begin tests_failed++; $display("FAIL uflow_sticky got %b exp 1", d_err); end
    rst = 1'b1;
    tick();
    rst = 1'b0; #1;
    tests_run++; if (d_err !== 1'b0) begin tests_failed++; $display("FAIL uflow_reset got %b exp 0", d_err); end
  endtask

  task automatic test_drain();
    do_reset();
    issue(5'd1);
    tick();
    issue(5'd2);
    tick();
    idle(); drain = 1'b1;
    tick();
    issue(5'd9); #1;
    tests_run++; if (d_ready !== 1'b0 || d_stall !== 1'b1) begin tests_failed++; $display("FAIL drain_block got ready=%b stall=%b exp 0 1", d_ready, d_stall); end
    tests_run++; if (d_drained !== 1'b0) begin tests_failed++; $display("FAIL drain_early got %b exp 0", d_drained); end
    cv = 1'b1; crd = 5'd1;
    tick();
    #1;
    tests_run++; if (d_drained !== 1'b0 || d_cnt !== 3'd1) begin tests_failed++; $display("FAIL drain_mid got drained=%b cnt=%0d exp 0 1", d_drained, d_cnt); end
    crd = 5'd2;
    tick();
    cv = 1'b0; #1;
    tests_run++; if (d_drained !== 1'b1 || d_cnt !== 3'd0) begin tests_failed++; $display("FAIL drain_done got drained=%b cnt=%0d exp 1 0", d_drained, d_cnt); end
    tests_run++; if (d_ready !== 1'b0) begin tests_failed++; $display("FAIL done_block got ready=%b exp 0", d_ready); end
    drain = 1'b0;
    tick();
    #1;
    tests_run++; if (d_drained !== 1'b0 || d_ready !== 1'b1) begin tests_failed++; $display("FAIL drain_exit got drained=%b ready=%b exp 0 1", d_drained, d_ready); end
    idle();
    tick();
    drain = 1'b1;
    tick();
    drain = 1'b0; #1;
    tests_run++; if (d_drained !== 1'b1) begin tests_failed++; $display("FAIL drain_empty got %b exp 1", d_drained); end
    tick();
    tests_run++; if (d_drained !== 1'b0) begin tests_failed++; $display("FAIL drain_empty_exit got %b exp 0", d_drained); end
  endtask

  task automatic test_same_rd_and_flush();
    do_reset();
    issue(5'd2);
    tick();
    cv = 1'b1; crd = 5'd2; #1;
    tests_run++; if (d_ready !== 1'b1) begin tests_failed++; $display("FAIL same_rd_ready got %b exp 1", d_ready); end
    tick();
    idle(); #1;
    tests_run++; if (d_busy[2] !== 1'b1 || d_cnt !== 3'd1) begin tests_failed++; $display("FAIL same_rd_hold got busy=%b cnt=%0d exp 1 1", d_busy[2], d_cnt); end
    cv = 1'b1; crd = 5'd2;
    tick();
    cv = 1'b0; #1;
    tests_run++; if (d_busy[2] !== 1'b0 || d_cnt !== 3'd0 || d_err !== 1'b0) begin tests_failed++; $display("FAIL same_rd_clear got busy=%b cnt=%0d err=%b exp 0 0 0", d_busy[2], d_cnt, d_err); end
    issue(5'd6); flush = 1'b1;
    tick();
    idle(); #1;
    tests_run++; if (d_busy !== '0 || d_cnt !== 3'd0) begin tests_failed++; $display("FAIL flush_nochange got busy=%h cnt=%0d exp 0 0", d_busy, d_cnt); end
  endtask

  initial begin
    idle();
    rst = 1'b0;
    tick();
    test_reset();
    test_raw_bypass();
    test_rs2_enable();
    test_full();
    test_waw();
    test_underflow();
    test_drain();
    test_same_rd_and_flush();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
